// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single fullsub cell, with a start/ready/busy/done handshake.

module fullsub (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] sd_reg;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;

  logic cell_d;
  logic cell_bo;
  logic last_bit;

  fullsub u_cell (
    .x  (sa_reg[0]),
    .y  (sb_reg[0]),
    .bi (br_reg),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_reg)
      IDLE: ready = 1'b1;
      RUN:  busy  = 1'b1;
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Datapath: operands shift right, each new difference bit enters at the MSB
  // so after WIDTH steps sd_reg holds the full result in natural order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sa_reg     <= '0;
      sb_reg     <= '0;
      sd_reg     <= '0;
      br_reg     <= 1'b0;
      cnt_reg    <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sa_reg  <= a;
            sb_reg  <= b;
            br_reg  <= bin;
            cnt_reg <= '0;
          end
        end
        RUN: begin
          sa_reg <= {1'b0, sa_reg[WIDTH-1:1]};
          sb_reg <= {1'b0, sb_reg[WIDTH-1:1]};
          sd_reg <= {cell_d, sd_reg[WIDTH-1:1]};
          br_reg <= cell_bo;
          if (last_bit) begin
            // Counter parks at WIDTH-1; the next accepted start clears it.
            diff_reg   <= {cell_d, sd_reg[WIDTH-1:1]};
            borrow_reg <= cell_bo;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff   = diff_reg;
  assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomised bench for serial_sub_ctrl; results compared with (a - b - bin) mod 512
// and the handshake compared with a fixed WIDTH+2 cycle timeline.

module tb_serial_sub_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;

  int n_vec;
  int n_bad;
  int prev_res;

  serial_sub_ctrl #(.WIDTH(8), .CW(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Idle cycles: nothing may start, result must hold.
  task automatic idle_cycles(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_ready", ready, 1);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_result", {23'd0, borrow, diff}, prev_res);
    end
  endtask

  // mode 0: single start pulse; 1: extra starts in cycles 3 and 9; 2: start held high.
  // Called with the clock low; operands accepted at the next rising edge (edge 0).
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic obin,
                        input int mode);
    int exp_res;
    exp_res = (int'(oa) - int'(ob) - int'(obin)) & 511;
    check("pre_ready", ready, 1);
    a = oa;
    b = ob;
    bin = obin;
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("busy", busy, (k <= 9) ? 1 : 0);
      check("ready", ready, (k == 10) ? 1 : 0);
      check("done", done, (k == 9) ? 1 : 0);
      if (k < 9) check("hold_result", {23'd0, borrow, diff}, prev_res);
      else       check("result", {23'd0, borrow, diff}, exp_res);
      a = 8'($urandom);
      b = 8'($urandom);
      bin = 1'($urandom);
      if (mode == 2)      start = 1'b1;
      else if (mode == 1) start = (k == 3 || k == 9);
      else                start = 1'b0;
    end
    prev_res = exp_res;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    prev_res = 0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", {23'd0, borrow, diff}, 0);
    reset = 1'b0;
    idle_cycles(2);

    run_op(8'd100, 8'd37, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    run_op(8'h55, 8'h55, 1'b1, 0);
    run_op(8'hFF, 8'h00, 1'b1, 0);
    run_op(8'd100, 8'd37, 1'b0, 1);
    idle_cycles(3);

    // Abort mid-RUN: reset raised during cycle 5.
    a = 8'hC3;
    b = 8'h11;
    bin = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("abort_busy", busy, 1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    prev_res = 0;
    check("abort_ready", ready, 1);
    check("abort_busy_low", busy, 0);
    check("abort_result", {23'd0, borrow, diff}, 0);
    check("abort_done", done, 0);
    idle_cycles(12);
    run_op(8'd100, 8'd37, 1'b0, 0);

    // Reset and start on the same edge: reset wins.
    a = 8'h0F;
    b = 8'hF0;
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    prev_res = 0;
    check("rststart_ready", ready, 1);
    check("rststart_busy", busy, 0);
    idle_cycles(3);

    // Back-to-back with start held high.
    for (int i = 0; i < 4; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 2);
    run_op(8'($urandom), 8'($urandom), 1'($urandom), 0);
    idle_cycles(1);

    for (int i = 0; i < 1000; i++) begin
      int mode;
      mode = (i == 999) ? 0 : int'($urandom_range(0, 2));
      run_op(8'($urandom), 8'($urandom), 1'($urandom), mode);
    end
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
